// File: rtl/axis_hex_pkg.sv
// Shared types and ASCII constants for the AXI-Stream hex transmitter.
package axis_hex_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIGIT = 2'd1,
    CR    = 2'd2,
    LF    = 2'd3
  } state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// Combinational conversion of one 4-bit nibble to its uppercase ASCII hex digit.
module hex_nibble_to_ascii
  import axis_hex_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] ascii_o
);

  always_comb begin
    if (nibble_i < 4'd10) ascii_o = ASCII_0 + {4'd0, nibble_i};
    else                  ascii_o = ASCII_A + {4'd0, nibble_i} - 8'd10;
  end

endmodule

// File: rtl/axis_hex_tx.sv
// Converts each input word into an ASCII hex frame (MSB nibble first, optional CR LF).
// Handshake: a beat transfers on a rising edge where valid & ready are both high; valid never depends on ready.
module axis_hex_tx
  import axis_hex_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int INCLUDE_CRLF = 1
) (
  input  logic                  aclk_i,
  input  logic                  arst_ni,
  input  logic                  s_axis_tvalid_i,
  output logic                  s_axis_tready_o,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_i,
  output logic                  m_axis_tvalid_o,
  input  logic                  m_axis_tready_i,
  output logic [7:0]            m_axis_tdata_o,
  output logic                  m_axis_tlast_o,
  output logic [11:0]           m_axis_tuser_o,
  output state_e                dbg_state_o
);

  localparam int NIBBLES = DATA_WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NIBBLES - 1);
  localparam bit CRLF = (INCLUDE_CRLF != 0);

  generate
    if (DATA_WIDTH < 4 || DATA_WIDTH > 64 || (DATA_WIDTH % 4) != 0) begin : g_bad_width
      $error("axis_hex_tx: DATA_WIDTH must be a multiple of 4 in 4..64");
    end
  endgenerate

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IDX_W-1:0]      idx_q, idx_d, next_idx;
  logic                  tvalid_q, tvalid_d;
  logic                  tready_q, tready_d;
  logic [7:0]            tdata_q, tdata_d;
  logic                  tlast_q, tlast_d;
  logic [11:0]           tuser_q, tuser_d;
  logic                  out_hs;

  logic [DATA_WIDTH-1:0] data_shifted;
  logic [7:0]            in_ascii, next_ascii;

  assign next_idx     = idx_q - IDX_W'(1);
  assign data_shifted = data_q >> {next_idx, 2'b00};
  assign out_hs       = tvalid_q & m_axis_tready_i;

  // First digit is converted straight from the input so it is ready the cycle after accept.
  hex_nibble_to_ascii u_in_conv (
    .nibble_i (s_axis_tdata_i[DATA_WIDTH-1 -: 4]),
    .ascii_o  (in_ascii)
  );

  hex_nibble_to_ascii u_next_conv (
    .nibble_i (data_shifted[3:0]),
    .ascii_o  (next_ascii)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    tdata_d = tdata_q;
    tlast_d = tlast_q;
    tuser_d = tuser_q;
    case (state_q)
      IDLE: begin
        if (s_axis_tvalid_i && tready_q) begin
          state_d = DIGIT;
          data_d  = s_axis_tdata_i;
          idx_d   = TOP_IDX;
          tdata_d = in_ascii;
          tlast_d = (NIBBLES == 1) && !CRLF;
        end
      end
      DIGIT: begin
        if (out_hs) begin
          if (idx_q == '0) begin
            if (CRLF) begin
              state_d = CR;
              tdata_d = ASCII_CR;
              tlast_d = 1'b0;
            end else begin
              state_d = IDLE;
              tdata_d = 8'h00;
              tlast_d = 1'b0;
              tuser_d = tuser_q + 12'd1;
            end
          end else begin
            idx_d   = next_idx;
            tdata_d = next_ascii;
            tlast_d = (next_idx == '0) && !CRLF;
          end
        end
      end
      CR: begin
        if (out_hs) begin
          state_d = LF;
          tdata_d = ASCII_LF;
          tlast_d = 1'b1;
        end
      end
      LF: begin
        if (out_hs) begin
          state_d = IDLE;
          tdata_d = 8'h00;
          tlast_d = 1'b0;
          tuser_d = tuser_q + 12'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Handshake flags are registered copies of the next state's decode.
    tvalid_d = (state_d != IDLE);
    tready_d = (state_d == IDLE);
  end

  always_ff @(posedge aclk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q  <= IDLE;
      data_q   <= '0;
      idx_q    <= '0;
      tvalid_q <= 1'b0;
      tready_q <= 1'b1;
      tdata_q  <= 8'h00;
      tlast_q  <= 1'b0;
      tuser_q  <= 12'd0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      idx_q    <= idx_d;
      tvalid_q <= tvalid_d;
      tready_q <= tready_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
    end
  end

  assign s_axis_tready_o = tready_q;
  assign m_axis_tvalid_o = tvalid_q;
  assign m_axis_tdata_o  = tdata_q;
  assign m_axis_tlast_o  = tlast_q;
  assign m_axis_tuser_o  = tuser_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_axis_hex_tx.sv
// Bench for axis_hex_tx: one instance with CR LF, one without; a scoreboard queue holds expected bytes.
module tb_axis_hex_tx;
  import axis_hex_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a_n, rst_b_n, sel;
  logic        s_valid, m_ready;
  logic [15:0] s_data;

  logic        a_s_ready, a_m_valid, a_m_last;
  logic [7:0]  a_m_data;
  logic [11:0] a_m_user;
  state_e      a_state;
  logic        b_s_ready, b_m_valid, b_m_last;
  logic [7:0]  b_m_data;
  logic [11:0] b_m_user;
  state_e      b_state;

  logic        s_ready, m_valid, m_last;
  logic [7:0]  m_data;
  logic [11:0] m_user;

  logic [20:0] exp_q[$];
  logic [11:0] exp_user;
  int          n_checks = 0;
  int          n_pass = 0;

  axis_hex_tx #(.DATA_WIDTH(16), .INCLUDE_CRLF(1)) dut (
    .aclk_i(clk), .arst_ni(rst_a_n),
    .s_axis_tvalid_i(s_valid), .s_axis_tready_o(a_s_ready), .s_axis_tdata_i(s_data),
    .m_axis_tvalid_o(a_m_valid), .m_axis_tready_i(m_ready), .m_axis_tdata_o(a_m_data),
    .m_axis_tlast_o(a_m_last), .m_axis_tuser_o(a_m_user), .dbg_state_o(a_state)
  );

  axis_hex_tx #(.DATA_WIDTH(16), .INCLUDE_CRLF(0)) dut_nc (
    .aclk_i(clk), .arst_ni(rst_b_n),
    .s_axis_tvalid_i(s_valid), .s_axis_tready_o(b_s_ready), .s_axis_tdata_i(s_data),
    .m_axis_tvalid_o(b_m_valid), .m_axis_tready_i(m_ready), .m_axis_tdata_o(b_m_data),
    .m_axis_tlast_o(b_m_last), .m_axis_tuser_o(b_m_user), .dbg_state_o(b_state)
  );

  always_comb begin
    s_ready = sel ? b_s_ready : a_s_ready;
    m_valid = sel ? b_m_valid : a_m_valid;
    m_data  = sel ? b_m_data  : a_m_data;
    m_last  = sel ? b_m_last  : a_m_last;
    m_user  = sel ? b_m_user  : a_m_user;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [15:0] w);
    logic [3:0] nib;
    logic [7:0] asc;
    logic       last;
    for (int i = 3; i >= 0; i--) begin
      nib  = w[i*4 +: 4];
      asc  = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
      last = (i == 0) && sel;
      exp_q.push_back({last, exp_user, asc});
    end
    if (!sel) begin
      exp_q.push_back({1'b0, exp_user, 8'h0D});
      exp_q.push_back({1'b1, exp_user, 8'h0A});
    end
    exp_user = exp_user + 12'd1;
  endtask

  task automatic send_word(input logic [15:0] w);
    int cyc = 0;
    push_frame(w);
    s_valid = 1'b1;
    s_data  = w;
    while (!s_ready && cyc < 300) begin
      step();
      cyc++;
    end
    n_checks++;
    if (s_ready !== 1'b1) $display("FAIL send_timeout: tready=%b after %0d cycles, required 1", s_ready, cyc);
    else n_pass++;
    step();
    s_valid = 1'b0;
  endtask

  task automatic drain(input int n, input bit rnd);
    int          got = 0;
    int          cyc = 0;
    bit          gap = 1'b0;
    bit          stall = 1'b0;
    logic [20:0] held, act, e;
    while ((got < n || gap) && cyc < 4000) begin
      act = {m_last, m_user, m_data};
      if (gap) begin
        n_checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1)
          $display("FAIL idle_gap: tvalid=%b tready=%b, required 0/1", m_valid, s_ready);
        else n_pass++;
        gap = 1'b0;
      end else begin
        if (stall) begin
          n_checks++;
          if (m_valid !== 1'b1 || act !== held)
            $display("FAIL stall_hold: valid=%b {last,user,data}=%h, required 1/%h", m_valid, act, held);
          else n_pass++;
        end
        if (m_valid === 1'b1) begin
          n_checks++;
          if (s_ready !== 1'b0) $display("FAIL busy_tready: tready=%b during frame, required 0", s_ready);
          else n_pass++;
        end
      end
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stall   = (m_valid === 1'b1) && !m_ready;
      held    = act;
      if (m_valid === 1'b1 && m_ready && got < n) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_byte: got %h with empty expected queue", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) $display("FAIL byte: {last,user,data}=%h, required %h", act, e);
          else n_pass++;
        end
        got++;
        if (act[20] === 1'b1) gap = 1'b1;
      end
      step();
      cyc++;
    end
    m_ready = 1'b0;
    n_checks++;
    if (got != n) $display("FAIL drain_timeout: received %0d bytes, required %0d", got, n);
    else n_pass++;
  endtask

  task automatic do_reset(input bit use_nc);
    sel      = use_nc;
    s_valid  = 1'b0;
    m_ready  = 1'b0;
    rst_a_n  = 1'b0;
    rst_b_n  = 1'b0;
    exp_q.delete();
    exp_user = 12'd0;
    step();
    step();
    if (use_nc) rst_b_n = 1'b1;
    else        rst_a_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    sel     = 1'b0;
    s_valid = 1'b1;
    s_data  = 16'hFFFF;
    m_ready = 1'b1;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    step();
    step();
    n_checks += 6;
    if (a_s_ready !== 1'b1) $display("FAIL reset_tready: %b, required 1", a_s_ready); else n_pass++;
    if (a_m_valid !== 1'b0) $display("FAIL reset_tvalid: %b, required 0", a_m_valid); else n_pass++;
    if (a_m_data !== 8'h00) $display("FAIL reset_tdata: %h, required 00", a_m_data); else n_pass++;
    if (a_m_last !== 1'b0)  $display("FAIL reset_tlast: %b, required 0", a_m_last); else n_pass++;
    if (a_m_user !== 12'd0) $display("FAIL reset_tuser: %0d, required 0", a_m_user); else n_pass++;
    if (a_state !== IDLE)   $display("FAIL reset_state: %0d, required IDLE", a_state); else n_pass++;
    s_valid = 1'b0;
    m_ready = 1'b0;
    exp_q.delete();
    exp_user = 12'd0;
    rst_a_n  = 1'b1;
    step();
  endtask

  task automatic test_single();
    send_word(16'h1A2F);
    drain(6, 1'b0);
  endtask

  task automatic test_stall();
    send_word(16'hBEEF);
    drain(6, 1'b1);
  endtask

  task automatic test_back_to_back();
    do_reset(1'b0);
    fork
      begin
        send_word(16'h0000);
        send_word(16'hFFFF);
      end
      drain(12, 1'b0);
    join
  endtask

  task automatic test_reset_mid();
    send_word(16'h1234);
    drain(2, 1'b0);
    rst_a_n = 1'b0;
    #1;
    n_checks += 3;
    if (a_m_valid !== 1'b0) $display("FAIL midreset_tvalid: %b, required 0", a_m_valid); else n_pass++;
    if (a_s_ready !== 1'b1) $display("FAIL midreset_tready: %b, required 1", a_s_ready); else n_pass++;
    if (a_m_user !== 12'd0) $display("FAIL midreset_tuser: %0d, required 0", a_m_user); else n_pass++;
    exp_q.delete();
    exp_user = 12'd0;
    step();
    rst_a_n = 1'b1;
    step();
    send_word(16'h5678);
    drain(6, 1'b0);
  endtask

  task automatic test_wrap();
    do_reset(1'b0);
    for (int f = 0; f < 4097; f++) begin
      send_word(16'($urandom));
      drain(6, 1'b0);
    end
  endtask

  task automatic test_nocrlf();
    do_reset(1'b1);
    fork
      begin
        send_word(16'h00C3);
        send_word(16'($urandom));
      end
      drain(8, 1'b0);
    join
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    test_nocrlf();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL leftover_expected: %0d bytes never seen, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_hex_tx.md
AXIS_HEX_TX -- requirements
Module: axis_hex_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of the input word; legal values are multiples of 4 in the range 4..64.
REQ-002 SHALL have parameter INCLUDE_CRLF, default 1: when 1, each frame ends with CR LF.
REQ-003 SHALL have a single clock and an asynchronous, active-low reset.
REQ-004 aclk_i  input  1  clock; all state updates on the rising edge.
REQ-005 arst_ni  input  1  asynchronous, active-low reset.
REQ-006 s_axis_tvalid_i  input  1  input word valid.
REQ-007 s_axis_tready_o  output  1  block can accept an input word.
REQ-008 s_axis_tdata_i  input  DATA_WIDTH  binary word to transmit.
REQ-009 m_axis_tvalid_o  output  1  output byte valid.
REQ-010 m_axis_tready_i  input  1  downstream accepts the byte.
REQ-011 m_axis_tdata_o  output  8  ASCII byte.
REQ-012 m_axis_tlast_o  output  1  last byte of the frame.
REQ-013 m_axis_tuser_o  output  12  frame sequence number.

Function
REQ-014 SHALL use an FSM with states IDLE, DIGIT, CR and LF.
REQ-015 In IDLE: s_axis_tready_o=1 and m_axis_tvalid_o=0; in every other state: s_axis_tready_o=0 and m_axis_tvalid_o=1.
REQ-016 An input handshake (s_axis_tvalid_i & s_axis_tready_o) SHALL latch s_axis_tdata_i, set the nibble index to DATA_WIDTH/4-1 and go to DIGIT.
REQ-017 m_axis_tvalid_o SHALL assert on the cycle after the input handshake (latency 1); all outputs SHALL be registered.
REQ-018 In DIGIT, m_axis_tdata_o SHALL be the ASCII hex of the indexed nibble, MSB nibble first: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46 (uppercase).
REQ-019 A byte advances only on an output handshake (m_axis_tvalid_o & m_axis_tready_i).
REQ-020 While m_axis_tready_i=0, m_axis_tdata_o, m_axis_tlast_o and m_axis_tuser_o SHALL hold stable, with no byte dropped or duplicated.
REQ-021 On an output handshake in DIGIT with index 0, the FSM SHALL go to CR if INCLUDE_CRLF=1, else to IDLE; otherwise the index SHALL decrement.
REQ-022 CR SHALL emit 0x0D then go to LF; LF SHALL emit 0x0A then go to IDLE.
REQ-023 m_axis_tlast_o=1 only on the final byte of a frame: LF if INCLUDE_CRLF=1, else the index-0 digit.
REQ-024 m_axis_tuser_o SHALL be constant for a whole frame and SHALL increment by 1 on the final-byte handshake, wrapping from 4095 to 0.
REQ-025 Frame length SHALL be DATA_WIDTH/4 + 2*INCLUDE_CRLF bytes; exactly one IDLE cycle SHALL separate frames (no input accept during a frame).
REQ-026 Input words offered during a frame SHALL stall (tready=0) and SHALL NOT be lost.
REQ-027 Illegal DATA_WIDTH SHALL cause an elaboration-time error.

Reset
REQ-028 While arst_ni=0: state=IDLE, s_axis_tready_o=1, m_axis_tvalid_o=0, m_axis_tdata_o=0x00, m_axis_tlast_o=0, m_axis_tuser_o=0, nibble index=0, data register=0.
REQ-029 Reset asserted mid-frame SHALL discard the frame immediately; after release the next accepted word starts a complete frame with tuser=0.

Structure
REQ-030 Package axis_hex_pkg SHALL hold the state enum typedef and the constants ASCII_CR=0x0D, ASCII_LF=0x0A, ASCII_0=0x30 and ASCII_A=0x41.
REQ-031 The nibble-to-ASCII conversion SHALL be a combinational sub-module hex_nibble_to_ascii (4-bit in, 8-bit out).

Verification
REQ-032 Word 0x1A2F with m_axis_tready_i=1 -> bytes 0x31,0x41,0x32,0x46,0x0D,0x0A; tlast only on 0x0A; tuser=0 throughout.
REQ-033 Word 0xBEEF with m_axis_tready_i toggling pseudo-randomly -> exactly 0x42,0x45,0x45,0x46,0x0D,0x0A, with data stable during every stall.
REQ-034 Back-to-back words 0x0000 then 0xFFFF held valid -> "0000\r\n" with tuser=0, then "FFFF\r\n" with tuser=1; s_axis_tready_o=0 during each frame.
REQ-035 INCLUDE_CRLF=0, word 0x00C3 -> 0x30,0x30,0x43,0x33 with tlast on 0x33; the next word is accepted after one IDLE cycle.
REQ-036 arst_ni pulsed low after 2 bytes of frame 0x1234 -> immediately tvalid=0, tready=1, tuser=0; word 0x5678 then yields the full "5678\r\n".
REQ-037 4096 consecutive frames -> tuser runs 0..4095, and frame 4097 carries tuser=0.
